isqrt: RTL and testbench

Sequential 16-bit unsigned integer square root, placed directly downstream of the 8x8 shift-add multiplier. It takes the multiplier's 16-bit product and returns the 8-bit floor root and the 9-bit remainder. It uses the same start/busy handshake as the multiplier, so the datapath controller can chain the two blocks without glue logic. The block runs one restoring digit-recurrence step per cycle, for 8 steps per operation.

---
 rtl/isqrt_pkg.sv | 18 +
 rtl/isqrt_step.sv | 27 ++
 rtl/isqrt.sv | 97 +++++++++
 tb/tb_isqrt.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/isqrt_pkg.sv
// Shared encodings and width constants for the sequential integer square root.
package isqrt_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WORK = 1'b1
  } state_e;

  localparam int OPND_W   = 16;
  localparam int ROOT_W   = 8;
  localparam int REM_W    = 9;
  localparam int STEP_CNT = 8;
  localparam int CTR_W    = 3;

  localparam logic [OPND_W-1:0] MASK_INIT = 16'h4000;
  localparam logic [CTR_W-1:0]  LAST_CTR  = 3'(STEP_CNT - 1);

endpackage

// File: rtl/isqrt_step.sv
// One restoring digit-recurrence step: trial-subtract root|mask from the remainder.
module isqrt_step
  import isqrt_pkg::*;
(
  input  logic [OPND_W-1:0] rem_i,
  input  logic [OPND_W-1:0] root_i,
  input  logic [OPND_W-1:0] mask_i,
  output logic [OPND_W-1:0] rem_o,
  output logic [OPND_W-1:0] root_o
);

  logic [OPND_W-1:0] trial_s;

  assign trial_s = root_i | mask_i;

  // Guarded subtract keeps rem non-negative; the root shifts right every step.
  always_comb begin
    if (rem_i >= trial_s) begin
      rem_o  = rem_i - trial_s;
      root_o = {1'b0, root_i[OPND_W-1:1]} | mask_i;
    end else begin
      rem_o  = rem_i;
      root_o = {1'b0, root_i[OPND_W-1:1]};
    end
  end

endmodule

// File: rtl/isqrt.sv
// 16-bit unsigned floor square root with remainder, one recurrence step per cycle.
module isqrt
  import isqrt_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [OPND_W-1:0] x_bi,
  input  logic              start_i,
  output logic              busy_o,
  output logic [ROOT_W-1:0] y_bo,
  output logic [REM_W-1:0]  r_bo
);

  state_e            state_q, state_d;
  logic [CTR_W-1:0]  ctr_q, ctr_d;
  logic [OPND_W-1:0] rem_q, rem_d;
  logic [OPND_W-1:0] root_q, root_d;
  logic [OPND_W-1:0] mask_q, mask_d;
  logic [ROOT_W-1:0] y_q, y_d;
  logic [REM_W-1:0]  r_q, r_d;
  logic [OPND_W-1:0] step_rem_s, step_root_s;

  isqrt_step u_step (
    .rem_i  (rem_q),
    .root_i (root_q),
    .mask_i (mask_q),
    .rem_o  (step_rem_s),
    .root_o (step_root_s)
  );

  // Next-state and datapath update; registers hold unless a transition says otherwise.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    rem_d   = rem_q;
    root_d  = root_q;
    mask_d  = mask_q;
    y_d     = y_q;
    r_d     = r_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          rem_d   = x_bi;
          root_d  = {OPND_W{1'b0}};
          mask_d  = MASK_INIT;
          ctr_d   = {CTR_W{1'b0}};
          state_d = WORK;
        end else begin
          state_d = IDLE;
        end
      end
      WORK: begin
        rem_d  = step_rem_s;
        root_d = step_root_s;
        mask_d = {2'b00, mask_q[OPND_W-1:2]};
        ctr_d  = ctr_q + 3'd1;
        // Upper bits of root and rem are zero by construction after the last step.
        if (ctr_q == LAST_CTR) begin
          y_d     = step_root_s[ROOT_W-1:0];
          r_d     = step_rem_s[REM_W-1:0];
          state_d = IDLE;
        end else begin
          state_d = WORK;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      ctr_q   <= {CTR_W{1'b0}};
      rem_q   <= {OPND_W{1'b0}};
      root_q  <= {OPND_W{1'b0}};
      mask_q  <= {OPND_W{1'b0}};
      y_q     <= {ROOT_W{1'b0}};
      r_q     <= {REM_W{1'b0}};
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      mask_q  <= mask_d;
      y_q     <= y_d;
      r_q     <= r_d;
    end
  end

  assign busy_o = start_i | (state_q != IDLE);
  assign y_bo   = y_q;
  assign r_bo   = r_q;

endmodule

// File: tb/tb_isqrt.sv
// Randomised self-checking bench for isqrt against a cycle-level arithmetic model.
module tb_isqrt;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] x_bi;
  logic        start_i;
  logic        busy_o;
  logic [7:0]  y_bo;
  logic [8:0]  r_bo;

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;

  isqrt dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .x_bi    (x_bi),
    .start_i (start_i),
    .busy_o  (busy_o),
    .y_bo    (y_bo),
    .r_bo    (r_bo)
  );

  always #5 clk_i = ~clk_i;

  function automatic int ref_root(input int x);
    int y = 0;
    while ((y + 1) * (y + 1) <= x) y++;
    return y;
  endfunction

  // Model: operand captured on the start edge, result appears 8 edges later.
  bit        m_busy = 1'b0;
  int        m_cnt = 0;
  int        m_x = 0;
  logic [7:0] m_y = 8'd0;
  logic [8:0] m_r = 9'd0;

  always @(posedge clk_i) begin
    if (!rst_i) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_y    <= 8'd0;
      m_r    <= 9'd0;
    end else if (!m_busy) begin
      if (start_i) begin
        m_busy <= 1'b1;
        m_cnt  <= 8;
        m_x    <= int'(x_bi);
      end
    end else begin
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        m_y    <= 8'(ref_root(m_x));
        m_r    <= 9'(m_x - ref_root(m_x) * ref_root(m_x));
      end
      m_cnt <= m_cnt - 1;
    end
  end

  always @(negedge clk_i) begin
    if (checking) begin
      vectors++;
      if (y_bo !== m_y || r_bo !== m_r || busy_o !== (start_i | m_busy)) begin
        miscompares++;
        $display("FAIL cycle t=%0t: got y=%0d r=%0d busy=%b, want y=%0d r=%0d busy=%b",
                 $time, y_bo, r_bo, busy_o, m_y, m_r, start_i | m_busy);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic start_pulse(input logic [15:0] x);
    x_bi    = x;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Waits for completion; optionally toggles x_bi/start_i during WORK to prove they are ignored.
  task automatic wait_done(input bit noise, output int n);
    n = 0;
    while (busy_o && n < 20) begin
      tick();
      n++;
      if (noise && n < 7) begin
        start_i = ($urandom_range(0, 3) == 0);
        x_bi    = 16'($urandom);
      end else begin
        start_i = 1'b0;
      end
    end
    if (busy_o) begin
      miscompares++;
      $display("FAIL timeout: busy_o still high after %0d cycles, want low", n);
    end
  endtask

  task automatic run_op(input logic [15:0] x, input bit noise, input int exp_y, input int exp_r,
                        input bit lit);
    int n;
    start_pulse(x);
    wait_done(noise, n);
    check("latency", n, 8);
    if (lit) begin
      check("y_lit", int'(y_bo), exp_y);
      check("r_lit", int'(r_bo), exp_r);
    end
  endtask

  initial begin
    int n;
    rst_i   = 1'b0;
    start_i = 1'b0;
    x_bi    = 16'd0;
    tick();
    tick();
    rst_i    = 1'b1;
    checking = 1'b1;
    check("reset_y", int'(y_bo), 0);
    check("reset_r", int'(r_bo), 0);
    check("reset_busy", int'(busy_o), 0);

    run_op(16'd0, 1'b0, 0, 0, 1'b1);
    check("zero_busy", int'(busy_o), 0);
    run_op(16'hFFFF, 1'b0, 255, 510, 1'b1);
    run_op(16'd144, 1'b0, 12, 0, 1'b1);

    // Stray start with x=9 while in WORK must not restart the operation.
    start_pulse(16'd200);
    tick(); tick();
    start_i = 1'b1;
    x_bi    = 16'd9;
    tick();
    start_i = 1'b0;
    wait_done(1'b0, n);
    check("ignored_start_lat", n, 5);
    check("y_200", int'(y_bo), 14);
    check("r_200", int'(r_bo), 4);

    // Back-to-back: start held, operand switched after the first start edge.
    x_bi    = 16'd225;
    start_i = 1'b1;
    tick();
    x_bi = 16'd50;
    repeat (8) tick();
    check("y_225", int'(y_bo), 15);
    check("r_225", int'(r_bo), 0);
    check("busy_held", int'(busy_o), 1);
    tick();
    start_i = 1'b0;
    repeat (7) tick();
    check("busy_mid_second", int'(busy_o), 1);
    check("y_225_held", int'(y_bo), 15);
    tick();
    check("y_50", int'(y_bo), 7);
    check("r_50", int'(r_bo), 1);
    check("busy_after_second", int'(busy_o), 0);

    // Reset mid-operation discards the in-flight result.
    start_pulse(16'd1000);
    repeat (4) tick();
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    check("midrst_y", int'(y_bo), 0);
    check("midrst_r", int'(r_bo), 0);
    check("midrst_busy", int'(busy_o), int'(start_i));
    run_op(16'd1000, 1'b0, 31, 39, 1'b1);

    // Perfect squares and their neighbours.
    for (int k = 1; k < 256; k += 17) begin
      run_op(16'(k * k), 1'b0, k, 0, 1'b1);
      run_op(16'(k * k - 1), 1'b0, k - 1, 2 * (k - 1), 1'b1);
    end

    for (int i = 0; i < 2000; i++) begin
      run_op(16'($urandom), 1'b1, 0, 0, 1'b0);
      if ($urandom_range(0, 3) == 0) tick();
    end

    tick();
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
    $fatal(1);
  end

endmodule
